// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Divide-by-zero completes immediately with an all-ones quotient and div_zero set.
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          c,
  input  logic          clr_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] dvd;
  logic [VW-1:0] dvs;
  logic [VW-1:0] part;
  logic [CW-1:0] cnt;

  logic          accept, dz_in, last, ge;
  logic [VW:0]   p;
  logic [VW-1:0] diff, part_nx;
  logic [DW-1:0] dvd_nx;

  // dvd doubles as the quotient register: dividend bits shift out the top
  // while quotient bits shift in at the bottom.
  always_comb begin
    accept  = (state == IDLE) && start;
    dz_in   = (divisor == '0);
    last    = (cnt == CW'(DW - 1));
    p       = {part, dvd[DW-1]};
    ge      = (p >= {1'b0, dvs});
    // true difference is below dvs, so the low VW bits are exact
    diff    = p[VW-1:0] - dvs;
    part_nx = ge ? diff : p[VW-1:0];
    dvd_nx  = {dvd[DW-2:0], ge};
  end

  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = dz_in ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge c or negedge clr_n) begin
    if (!clr_n) begin
      dvd       <= '0;
      dvs       <= '0;
      part      <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      dvd  <= dividend;
      dvs  <= divisor;
      part <= '0;
      cnt  <= '0;
      if (dz_in) begin
        quotient  <= '1;
        remainder <= '0;
        div_zero  <= 1'b1;
      end
    end else if (state == RUN) begin
      dvd  <= dvd_nx;
      part <= part_nx;
      cnt  <= cnt + 1'b1;
      if (last) begin
        quotient  <= dvd_nx;
        remainder <= part_nx;
        div_zero  <= 1'b0;
      end
    end
  end

endmodule
